// File: rtl/dwc_pkg.sv
// Shared types for the duplicate-with-compare round controller.
// Holds the FSM state and round-outcome encodings plus a saturating increment.
package dwc_pkg;

  localparam int MM_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    COMPARE,
    IRQ_WAIT,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE     = 2'b00,
    RES_MATCH    = 2'b01,
    RES_MISMATCH = 2'b10,
    RES_TIMEOUT  = 2'b11
  } result_t;

  function automatic logic [MM_CNT_W-1:0] sat_inc(
    input logic [MM_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dwc_watchdog.sv
// Partner-core watchdog: counts while enabled, expire at TIMEOUT_CYC-1.
// Ports: clk, reset (async high), clr, en -> expire.
module dwc_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/dwc_round_ctrl.sv
// Duplicate-with-compare round sequencer for two cores (A, B); macro DWC_TIMEOUT_EN
// enables the partner watchdog. Ports: clk, reset, a/b_data, a/b_wr, irq_ack ->
// irq, result, mismatch_cnt, round_cnt, overrun, fault, busy.
import dwc_pkg::*;

module dwc_round_ctrl #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYC    = 1024,
  parameter int MISMATCH_LIMIT = 3,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_wr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_wr,
  input  logic              irq_ack,
  output logic              irq,
  output logic [1:0]        result,
  output logic [7:0]        mismatch_cnt,
  output logic [CNT_W-1:0]  round_cnt,
  output logic              overrun,
  output logic              fault,
  output logic              busy
);

  localparam logic [MM_CNT_W-1:0] MM_LIM = MM_CNT_W'(MISMATCH_LIMIT);

  state_t               state;
  state_t               state_nx;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;
  logic                 have_a;
  logic                 have_b;
  result_t              res_q;
  logic [MM_CNT_W-1:0]  mm_q;
  logic                 expire;
  logic                 cap_a;
  logic                 cap_b;
  logic                 drop;
  logic                 partner;
  logic                 tmo;
  logic                 ack;

`ifdef DWC_TIMEOUT_EN
  dwc_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk   (clk),
    .reset (reset),
    .clr   (state != COLLECT),
    .en    (state == COLLECT),
    .expire(expire)
  );
`else
  // No watchdog: COLLECT waits for the partner forever.
  assign expire = (TIMEOUT_CYC < 0);
`endif

  // A side is captured in IDLE, or in COLLECT only if it is still missing.
  assign cap_a = a_wr && (state == IDLE ||
                 (state == COLLECT && !have_a));
  assign cap_b = b_wr && (state == IDLE ||
                 (state == COLLECT && !have_b));

  assign drop = ((a_wr && !cap_a) || (b_wr && !cap_b)) &&
                (state inside {COLLECT, COMPARE, IRQ_WAIT});

  // A partner strobe on the expiry cycle beats the timeout.
  assign partner = (state == COLLECT) && (cap_a || cap_b);
  assign tmo     = expire && !partner;
  assign ack     = (state == IRQ_WAIT) && irq_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (a_wr && b_wr) begin
          state_nx = COMPARE;
        end else if (a_wr || b_wr) begin
          state_nx = COLLECT;
        end
      end
      COLLECT: begin
        if (partner) begin
          state_nx = COMPARE;
        end else if (tmo) begin
          state_nx = IRQ_WAIT;
        end
      end
      COMPARE: state_nx = IRQ_WAIT;
      IRQ_WAIT: begin
        if (ack) begin
          state_nx = (mm_q >= MM_LIM) ? FAULT : IDLE;
        end
      end
      FAULT:   state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    irq          = (state == IRQ_WAIT);
    busy         = (state != IDLE);
    fault        = (state == FAULT);
    result       = res_q;
    mismatch_cnt = mm_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      have_a    <= 1'b0;
      have_b    <= 1'b0;
      res_q     <= RES_NONE;
      mm_q      <= '0;
      round_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      if (cap_a) begin
        a_q    <= a_data;
        have_a <= 1'b1;
      end
      if (cap_b) begin
        b_q    <= b_data;
        have_b <= 1'b1;
      end
      if (state == COMPARE) begin
        if (a_q == b_q) begin
          res_q <= RES_MATCH;
          mm_q  <= '0;
        end else begin
          res_q <= RES_MISMATCH;
          mm_q  <= sat_inc(mm_q);
        end
      end
      if (tmo) begin
        res_q <= RES_TIMEOUT;
        mm_q  <= sat_inc(mm_q);
      end
      if (ack) begin
        round_cnt <= round_cnt + 1'b1;
        have_a    <= 1'b0;
        have_b    <= 1'b0;
        overrun   <= 1'b0;
      end
      // A drop on the ack cycle still leaves overrun set.
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dwc_round_ctrl.sv
// Scoreboard bench for dwc_round_ctrl: rounds are modelled at the
// round level, expected outcomes queued and checked on each irq rise.
module tb_dwc_round_ctrl;

  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam int LIM = 3;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] a_data = '0;
  logic          a_wr = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic          b_wr = 1'b0;
  logic          irq_ack = 1'b0;
  logic          irq;
  logic [1:0]    result;
  logic [7:0]    mismatch_cnt;
  logic [CW-1:0] round_cnt;
  logic          overrun;
  logic          fault;
  logic          busy;

  dwc_round_ctrl #(
    .DATA_W(DW),
    .TIMEOUT_CYC(TO),
    .MISMATCH_LIMIT(LIM),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_data(a_data),
    .a_wr(a_wr),
    .b_data(b_data),
    .b_wr(b_wr),
    .irq_ack(irq_ack),
    .irq(irq),
    .result(result),
    .mismatch_cnt(mismatch_cnt),
    .round_cnt(round_cnt),
    .overrun(overrun),
    .fault(fault),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  res;
    logic [7:0]  mm;
    logic        ovr;
    logic [15:0] rc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   m_mm = 0;
  int   m_rc = 0;
  bit   m_fault = 1'b0;
  logic irq_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising irq must match the oldest queued round.
  always @(negedge clk) begin
    if (irq && !irq_d) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_irq: got irq=1 expected none");
      end else begin
        me = q.pop_front();
        chk("mon_result", 32'(result), 32'(me.res));
        chk("mon_mismatch_cnt", 32'(mismatch_cnt), 32'(me.mm));
        chk("mon_overrun", 32'(overrun), 32'(me.ovr));
        chk("mon_round_cnt", 32'(round_cnt), 32'(me.rc));
      end
    end
    irq_d <= irq;
  end

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic drive_a(input logic [31:0] v);
    a_data = v;
    a_wr   = 1'b1;
  endtask

  task automatic drive_b(input logic [31:0] v);
    b_data = v;
    b_wr   = 1'b1;
  endtask

  task automatic ack_round();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    m_rc++;
    m_fault = (m_mm >= LIM);
    chk("ack_irq_low", 32'(irq), 0);
    chk("ack_round_cnt", 32'(round_cnt), 32'(m_rc));
    chk("ack_overrun_clr", 32'(overrun), 0);
    chk("ack_fault", 32'(fault), 32'(m_fault));
    chk("ack_busy", 32'(busy), 32'(m_fault));
  endtask

  // One round: first side strobes, the other follows gap cycles later
  // (gap 0 = same cycle). dup repeats the first side in between.
  task automatic round(input logic [31:0] av, input logic [31:0] bv,
                       input int gap, input bit b_first,
                       input bit dup_in, input logic [31:0] dv,
                       input bit late, input bit do_ack);
    bit   dup;
    exp_t e;
    dup   = dup_in && (gap >= 2);
    e.res = (av == bv) ? 2'b01 : 2'b10;
    m_mm  = (av == bv) ? 0 : sat(m_mm);
    e.mm  = 8'(m_mm);
    e.ovr = dup;
    e.rc  = 16'(m_rc);
    q.push_back(e);
    @(negedge clk);
    if (gap == 0) begin
      drive_a(av);
      drive_b(bv);
    end else if (b_first) begin
      drive_b(bv);
    end else begin
      drive_a(av);
    end
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      a_wr = 1'b0;
      b_wr = 1'b0;
      if (i == gap) begin
        if (b_first) drive_a(av);
        else drive_b(bv);
      end else if (dup && i == 1) begin
        if (b_first) drive_b(dv);
        else drive_a(dv);
      end
    end
    @(negedge clk);
    a_wr = 1'b0;
    b_wr = 1'b0;
    chk("lat_compare_irq_low", 32'(irq), 0);
    @(negedge clk);
    chk("lat_irq_high", 32'(irq), 1);
    chk("round_busy", 32'(busy), 1);
    if (late) begin
      drive_a(32'h0BAD);
      @(negedge clk);
      a_wr = 1'b0;
      chk("late_overrun", 32'(overrun), 1);
      chk("late_irq_held", 32'(irq), 1);
    end
    if (do_ack) ack_round();
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_mm"}, 32'(mismatch_cnt), 0);
    chk({tag, "_rc"}, 32'(round_cnt), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    @(negedge clk);
    reset   = 1'b0;
    m_mm    = 0;
    m_rc    = 0;
    m_fault = 1'b0;
    q.delete();
  endtask

`ifdef DWC_TIMEOUT_EN
  // Watchdog starts on COLLECT entry, so the expiry cycle is TO
  // cycles after the first strobe.
  task automatic timeout_round(input bit partner,
                               input logic [31:0] av,
                               input logic [31:0] bv);
    exp_t e;
    if (partner) begin
      e.res = (av == bv) ? 2'b01 : 2'b10;
      m_mm  = (av == bv) ? 0 : sat(m_mm);
    end else begin
      e.res = 2'b11;
      m_mm  = sat(m_mm);
    end
    e.mm  = 8'(m_mm);
    e.ovr = 1'b0;
    e.rc  = 16'(m_rc);
    q.push_back(e);
    @(negedge clk);
    drive_a(av);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      a_wr = 1'b0;
    end
    if (partner) drive_b(bv);
    else chk("to_irq_low_expiry", 32'(irq), 0);
    @(negedge clk);
    b_wr = 1'b0;
    chk("to_irq_next", 32'(irq), partner ? 0 : 1);
    if (partner) begin
      @(negedge clk);
      chk("to_partner_irq", 32'(irq), 1);
    end
    ack_round();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] av;
    logic [31:0] bv;
    #3;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_mm", 32'(mismatch_cnt), 0);
    chk("rst_rc", 32'(round_cnt), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;

    round(32'hDEADBEEF, 32'hDEADBEEF, 3, 0, 0, 0, 0, 1);
    round(32'h1, 32'h2, 0, 0, 0, 0, 0, 1);
    round(32'h77, 32'h77, 1, 1, 0, 0, 0, 1);
    round(32'h5, 32'h5, 3, 0, 1, 32'h6, 1, 1);
    round(32'h9, 32'h9, 4, 1, 1, 32'h3, 0, 1);

`ifdef DWC_TIMEOUT_EN
    timeout_round(0, 32'h11, 32'h0);
    timeout_round(1, 32'h22, 32'h22);
    timeout_round(0, 32'h33, 32'h0);
    timeout_round(1, 32'h44, 32'h45);
`else
    round(32'hCAFE, 32'hCAFE, 40, 0, 0, 0, 0, 1);
`endif

    async_reset("pre_esc");
    round(32'hA, 32'hB, 2, 0, 0, 0, 0, 1);
    round(32'hC, 32'hC, 2, 1, 0, 0, 0, 1);
    round(32'hA, 32'hB, 2, 0, 0, 0, 0, 1);
    round(32'hA, 32'hB, 2, 0, 0, 0, 0, 1);

    async_reset("esc");
    round(32'h1, 32'h2, 1, 0, 0, 0, 0, 1);
    round(32'h3, 32'h4, 0, 0, 0, 0, 0, 1);
    round(32'h5, 32'h6, 2, 1, 0, 0, 0, 1);
    chk("esc_fault_model", 32'(m_fault), 1);
    @(negedge clk);
    drive_a(32'h1);
    drive_b(32'h1);
    @(negedge clk);
    a_wr = 1'b0;
    b_wr = 1'b0;
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("fault_irq", 32'(irq), 0);
    chk("fault_rc_frozen", 32'(round_cnt), 3);
    chk("fault_sticky", 32'(fault), 1);
    chk("fault_busy", 32'(busy), 1);
    chk("fault_no_overrun", 32'(overrun), 0);
    chk("fault_result", 32'(result), 32'h2);
    async_reset("fault_rst");

    @(negedge clk);
    drive_a(32'h7);
    @(negedge clk);
    a_wr = 1'b0;
    @(negedge clk);
    chk("collect_busy", 32'(busy), 1);
    async_reset("collect_rst");
    repeat (3) @(negedge clk);
    chk("post_rst_irq", 32'(irq), 0);
    chk("post_rst_busy", 32'(busy), 0);
    round(32'h8, 32'h8, 2, 1, 0, 0, 0, 1);

    round(32'h10, 32'h20, 1, 0, 0, 0, 0, 0);
    async_reset("irqwait_rst");
    round(32'h30, 32'h30, 0, 0, 0, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      av = $urandom;
      bv = ($urandom_range(0, 1) == 1) ? av : $urandom;
      round(av, bv, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), 1);
      if (m_fault) async_reset("rand_fault");
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
